alu_serial_ctrl: RTL and testbench
==================================

# alu_serial_ctrl

Bit-serial sequencer that runs a full WIDTH-bit ALU operation through a single combinational 1-bit ALU slice. It sits directly upstream and downstream of that slice. Each cycle it drives the slice with one operand bit, the decoded invert/op controls, the registered carry and the `less` input. It then captures the slice's `result`, `c_out`, `set` and `overflow` outputs into a WIDTH-bit result register. A start/busy/done handshake lets a datapath or bench issue one operation at a time.

## Interface
- `WIDTH`, 32, operand and result width in bits (≥2).

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  synchronous active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `ctrl`  in  4  ALU control; sampled with `start`.
  - 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
- `src_a`  in  WIDTH  operand A; sampled with `start`.
- `src_b`  in  WIDTH  operand B; sampled with `start`.
- `busy`  out  1  high in RUN and FIXUP.
- `done`  out  1  one-cycle completion pulse.
- `alu_result`  out  WIDTH  registered result; held until the next completion.
- `zero`  out  1  registered `alu_result == 0`.
- `ovf`  out  1  registered signed overflow.
- `s_a`, `s_b`  out  1  current operand bits to the slice.
- `s_less`  out  1  slice `less` input.
- `s_ainvert`, `s_binvert`  out  1  slice invert controls.
- `s_cin`  out  1  slice carry-in.
- `s_op`  out  2  slice op select.
- `s_result`, `s_cout`, `s_set`, `s_overflow`  in  1  slice outputs; combinational from the `s_*` drives in the same cycle.

## Operation
- **Decode** at start: `ainv = ctrl[3]`, `binv = ctrl[2]`, `op = ctrl[1:0]`.
  - Undefined codes execute with this raw decode.
- **Latched on start:** operands, decoded fields, bit index `i` = 0, `carry` = `binv`.
- **States:** IDLE, RUN, FIXUP, DONE.
- **IDLE:**
  - `start` = 1 → RUN.
  - Otherwise stay in IDLE.
- **RUN:** the slice is driven with:
  - `s_a = A[i]`, `s_b = B[i]`, `s_cin = carry`, `s_less = 0`.
  - `s_ainvert = ainv`, `s_binvert = binv`, `s_op = op`.
- **RUN, each edge:**
  - `res[i] <= s_result`, `carry <= s_cout`, `i <= i+1`.
- **RUN, at `i = WIDTH-1`:**
  - Capture `set_msb <= s_set` and `ovf_msb <= s_overflow`.
  - Next state is FIXUP if `op` = 11, else DONE.
- **FIXUP** (SLT only):
  - Drive bit-0 operands with `s_less = set_msb` and `s_op = 11`.
  - Capture `res[0] <= s_result`.
  - → DONE.
  - `res` bits [WIDTH-1:1] are 0, because they were computed with `less = 0`.
  - No overflow correction is applied; SLT follows the slice's raw `set`.
- **Register updates on entry to DONE** (same edge):
  - `alu_result <= res`, `zero <= (res == 0)`.
  - `ovf <= ovf_msb` for ctrl 0010/0110; `ovf <= 0` otherwise.
- **DONE:** `done` = 1 for exactly one cycle → IDLE unconditionally.
- **Outside RUN/FIXUP:** all `s_*` outputs are 0.
- **`start` outside IDLE** (RUN, FIXUP, DONE): ignored and not queued. Input changes after the start cycle have no effect.
- **Reset** (`rst_n` = 0 at an edge, any state, including mid-RUN): the current operation is discarded and not completed.
  - State → IDLE.
  - `i`, `carry`, `res`, `set_msb`, `ovf_msb` → 0.
  - `alu_result`, `zero`, `ovf`, `busy`, `done`, all `s_*` → 0.

## Timing
- Edge 0 samples `start`. RUN occupies the WIDTH cycles after edge 0, and edges 1..WIDTH capture bits 0..WIDTH-1.
- **Non-SLT:** `done` and the new results are visible WIDTH cycles after the sampling edge.
- **SLT:** WIDTH+1 cycles.
- Results stay stable from the `done` cycle until the next completion.
- **Minimum issue interval** with `start` held high (one IDLE cycle is mandatory):
  - Non-SLT: WIDTH+2 cycles.
  - SLT: WIDTH+3 cycles.
- `busy` rises the cycle after the start edge and falls in the `done` cycle.
- The carry chain is registered: exactly one slice evaluation per cycle, and no combinational path from `s_cout` to `s_cin`.

## Test plan
Bench: WIDTH = 32, slice instantiated on the `s_*` ports.
1. ADD 0x7FFFFFFF + 0x00000001 → `alu_result` 0x80000000, `ovf` = 1, `zero` = 0. `done` exactly 32 cycles after the start edge, `busy` high for 32 cycles.
2. SUB 0x00000005 − 0x00000005 → 0x00000000, `zero` = 1, `ovf` = 0. SUB 0x80000000 − 0x00000001 → 0x7FFFFFFF, `ovf` = 1.
3. SLT A = 0xFFFFFFFD, B = 0x00000002 → 0x00000001, `zero` = 0, `done` at 33 cycles. SLT A = 0x00000002, B = 0xFFFFFFFD → 0x00000000, `zero` = 1, `ovf` = 0.
4. Logic ops on A = 0x0F0F0000, B = 0x00FF00FF: AND → 0x000F0000, OR → 0x0FFF00FF, NOR → 0xF000FF00. `ovf` = 0 for all three.
5. Start ADD 1 + 1. Pulse `start` with SUB at cycle 10 → ignored; result 0x00000002, single `done`. Next, start ADD and drop `rst_n` at cycle 15 → next cycle shows `busy` = 0, `alu_result` = 0, all `s_*` = 0, no `done`. A following ADD 3 + 4 → 0x00000007.
6. `start` held high with ADD 1 + 2 → `done` pulses every 34 cycles, each with 0x00000003. Each `done` pulse precedes one IDLE cycle before RUN restarts.

Source files
------------

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: steps a WIDTH-bit operation through an external
// combinational 1-bit ALU slice, one bit per cycle, with a registered carry chain.
module alu_serial_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_result,
    output logic             zero,
    output logic             ovf,
    output logic             s_a,
    output logic             s_b,
    output logic             s_less,
    output logic             s_ainvert,
    output logic             s_binvert,
    output logic             s_cin,
    output logic [1:0]       s_op,
    input  logic             s_result,
    input  logic             s_cout,
    input  logic             s_set,
    input  logic             s_overflow
);

    localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIXUP,
        S_DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic [IW-1:0]    idx;
    logic             ainv_q;
    logic             binv_q;
    logic [1:0]       op_q;
    logic             arith_q;
    logic             carry;
    logic             set_msb;
    logic             ovf_msb;
    logic             last_bit;

    assign last_bit = (idx == IW'(WIDTH - 1));

    // Result with this cycle's slice output merged in, so the final bit can be
    // published on the same edge that captures it.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        res_next = res;
        if (state == S_RUN) begin
            res_next[idx] = s_result;
        end else if (state == S_FIXUP) begin
            res_next[0] = s_result;
        end
    end

    // Slice drives are decoded from registered state only; s_cout never reaches s_cin.
    always_comb begin
        s_a       = 1'b0;
        s_b       = 1'b0;
        s_less    = 1'b0;
        s_ainvert = 1'b0;
        s_binvert = 1'b0;
        s_cin     = 1'b0;
        s_op      = 2'b00;
        case (state)
            S_RUN: begin
                s_a       = a_q[idx];
                s_b       = b_q[idx];
                s_cin     = carry;
                s_ainvert = ainv_q;
                s_binvert = binv_q;
                s_op      = op_q;
            end
            S_FIXUP: begin
                s_a       = a_q[0];
                s_b       = b_q[0];
                s_less    = set_msb;
                s_ainvert = ainv_q;
                s_binvert = binv_q;
                s_op      = 2'b11;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            res        <= '0;
            idx        <= '0;
            ainv_q     <= 1'b0;
            binv_q     <= 1'b0;
            op_q       <= 2'b00;
            arith_q    <= 1'b0;
            carry      <= 1'b0;
            set_msb    <= 1'b0;
            ovf_msb    <= 1'b0;
            alu_result <= '0;
            zero       <= 1'b0;
            ovf        <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= src_a;
                        b_q     <= src_b;
                        ainv_q  <= ctrl[3];
                        binv_q  <= ctrl[2];
                        op_q    <= ctrl[1:0];
                        arith_q <= (ctrl == 4'b0010) || (ctrl == 4'b0110);
                        carry   <= ctrl[2];
                        idx     <= '0;
                        res     <= '0;
                        busy    <= 1'b1;
                        state   <= S_RUN;
                    end
                end
                S_RUN: begin
                    res   <= res_next;
                    carry <= s_cout;
                    idx   <= idx + 1'b1;
                    if (last_bit) begin
                        idx     <= '0;
                        set_msb <= s_set;
                        ovf_msb <= s_overflow;
                        if (op_q == 2'b11) begin
                            state <= S_FIXUP;
                        end else begin
                            alu_result <= res_next;
                            zero       <= (res_next == '0);
                            ovf        <= arith_q & s_overflow;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            state      <= S_DONE;
                        end
                    end
                end
                S_FIXUP: begin
                    // Upper bits were produced with less = 0; only bit 0 carries the set flag.
                    res        <= res_next;
                    alu_result <= res_next;
                    zero       <= (res_next == '0);
                    ovf        <= arith_q & ovf_msb;
                    busy       <= 1'b0;
                    done       <= 1'b1;
                    state      <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Scoreboard bench for alu_serial_ctrl with a behavioural 1-bit ALU slice on the s_* ports.
module tb_alu_serial_ctrl;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [3:0]    ctrl;
    logic [W-1:0]  src_a;
    logic [W-1:0]  src_b;
    logic          busy;
    logic          done;
    logic [W-1:0]  alu_result;
    logic          zero;
    logic          ovf;
    logic          s_a, s_b, s_less, s_ainvert, s_binvert, s_cin;
    logic [1:0]    s_op;
    logic          s_result, s_cout, s_set, s_overflow;

    typedef struct {
        logic [W-1:0] res;
        logic         zero;
        logic         ovf;
        string        tag;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   done_seen = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .ctrl(ctrl),
        .src_a(src_a), .src_b(src_b), .busy(busy), .done(done),
        .alu_result(alu_result), .zero(zero), .ovf(ovf),
        .s_a(s_a), .s_b(s_b), .s_less(s_less), .s_ainvert(s_ainvert),
        .s_binvert(s_binvert), .s_cin(s_cin), .s_op(s_op),
        .s_result(s_result), .s_cout(s_cout), .s_set(s_set), .s_overflow(s_overflow)
    );

    // 1-bit ALU slice
    logic ae, be, sum;
    always_comb begin
        ae         = s_a ^ s_ainvert;
        be         = s_b ^ s_binvert;
        sum        = ae ^ be ^ s_cin;
        s_cout     = (ae & be) | (ae & s_cin) | (be & s_cin);
        s_set      = sum;
        s_overflow = s_cin ^ s_cout;
        case (s_op)
            2'b00:   s_result = ae & be;
            2'b01:   s_result = ae | be;
            2'b10:   s_result = sum;
            default: s_result = s_less;
        endcase
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse is matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            exp_t e;
            done_seen++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected done: got result %h, expected no completion", alu_result);
            end else begin
                e = sb.pop_front();
                check({e.tag, " result"}, alu_result, e.res);
                check({e.tag, " zero"}, W'(zero), W'(e.zero));
                check({e.tag, " ovf"}, W'(ovf), W'(e.ovf));
            end
        end
    end

    task automatic expect_result(input string tag, input logic [W-1:0] r, input logic ov);
        exp_t e;
        e.res  = r;
        e.zero = (r == '0);
        e.ovf  = ov;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    // Bounded wait for done; returns negedges elapsed and busy-high count.
    task automatic wait_done(output int k, output int bcnt);
        k = 0;
        bcnt = 0;
        while (done !== 1'b1 && k < 80) begin
            if (busy === 1'b1) bcnt++;
            @(negedge clk);
            k++;
        end
    endtask

    // Issue one op from an IDLE negedge; returns at the negedge after done.
    task automatic run_op(input string tag, input logic [3:0] c, input logic [W-1:0] a,
                          input logic [W-1:0] b, input logic [W-1:0] r, input logic ov,
                          input int lat);
        int k, bcnt;
        expect_result(tag, r, ov);
        start = 1'b1; ctrl = c; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0;
        wait_done(k, bcnt);
        check({tag, " latency"}, W'(k), W'(lat));
        check({tag, " busy cycles"}, W'(bcnt), W'(lat));
        check({tag, " busy in done"}, W'(busy), '0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int k, bcnt, seen0, t_prev;
        rst_n = 1'b0; start = 1'b0; ctrl = 4'b0; src_a = '0; src_b = '0;
        repeat (2) @(negedge clk);
        check("reset busy/done/zero/ovf", W'({busy, done, zero, ovf}), '0);
        check("reset result", alu_result, '0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("ADD ovf", 4'b0010, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 32);
        run_op("SUB zero", 4'b0110, 32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 32);
        run_op("SUB ovf", 4'b0110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 32);
        run_op("SLT true", 4'b0111, 32'hFFFF_FFFD, 32'h0000_0002, 32'h0000_0001, 1'b0, 33);
        run_op("SLT false", 4'b0111, 32'h0000_0002, 32'hFFFF_FFFD, 32'h0000_0000, 1'b0, 33);
        run_op("AND", 4'b0000, 32'h0F0F_0000, 32'h00FF_00FF, 32'h000F_0000, 1'b0, 32);
        run_op("OR", 4'b0001, 32'h0F0F_0000, 32'h00FF_00FF, 32'h0FFF_00FF, 1'b0, 32);
        run_op("NOR", 4'b1100, 32'h0F0F_0000, 32'h00FF_00FF, 32'hF000_FF00, 1'b0, 32);

        // start while busy is ignored, and input changes after the start cycle have no effect
        seen0 = done_seen;
        expect_result("ADD ignore", 32'h0000_0002, 1'b0);
        start = 1'b1; ctrl = 4'b0010; src_a = 32'd1; src_b = 32'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1; ctrl = 4'b0110; src_a = 32'd9; src_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        wait_done(k, bcnt);
        check("ignore latency", W'(k + 10), 32'd32);
        repeat (40) @(negedge clk);
        check("ignore done count", W'(done_seen - seen0), 32'd1);

        // reset mid-RUN discards the operation
        seen0 = done_seen;
        start = 1'b1; ctrl = 4'b0010; src_a = 32'd10; src_b = 32'd20;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst busy/done", W'({busy, done}), '0);
        check("rst result", alu_result, '0);
        check("rst s_*", W'({s_a, s_b, s_less, s_ainvert, s_binvert, s_cin, s_op}), '0);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        check("rst no done", W'(done_seen - seen0), '0);
        run_op("ADD after rst", 4'b0010, 32'd3, 32'd4, 32'h0000_0007, 1'b0, 32);

        // back-to-back with start held high
        repeat (3) expect_result("ADD held", 32'h0000_0003, 1'b0);
        start = 1'b1; ctrl = 4'b0010; src_a = 32'd1; src_b = 32'd2;
        t_prev = 0;
        for (int p = 0; p < 3; p++) begin
            wait_done(k, bcnt);
            if (p == 2) start = 1'b0;
            if (p > 0) check("held interval", W'(cyc - t_prev), 32'd34);
            t_prev = cyc;
            @(negedge clk);
            check("held idle gap", W'({busy, done}), '0);
            if (p < 2) begin
                @(negedge clk);
                check("held restart busy", W'(busy), 32'd1);
            end
        end
        repeat (40) @(negedge clk);
        check("scoreboard drained", W'(sb.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
